// File: rtl/oni_stack_pkg.sv
// Shared types for the stack controller: command opcodes, controller
// states and the bit positions inside err_flags.
package oni_stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_WR = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

endpackage

// File: rtl/oni_stack_ctrl.sv
// Hardware stack controller: keeps a downward-growing stack in external
// memory between STACK_BOTTOM and STACK_TOP, serves one PUSH/POP/PEEK/CLEAR
// command at a time and tracks occupancy, high-water mark and sticky errors.
//
// Handshakes:
//   cmd:  a command is taken on a rising edge where cmd_valid && cmd_ready;
//         cmd_op/cmd_data are captured on that edge. cmd_ready is high only
//         while idle, so exactly one command is in flight.
//   mem:  mem_req (with mem_we/mem_addr/mem_wdata) stays high and stable until
//         a rising edge sees mem_ack; mem_rdata is taken on that same edge.
//         Acking in the very first request cycle is allowed. mem_ack seen
//         while no request is outstanding is ignored.
//   rsp:  rsp_valid is a one-cycle pulse with rsp_data/rsp_err, no back-pressure.
module oni_stack_ctrl
  import oni_stack_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] STACK_TOP    = 16'h9FFF,
  parameter logic [ADDR_W-1:0] STACK_BOTTOM = 16'h9000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   hwm,
  output logic [1:0]        err_flags,
  input  logic              err_clr,
  output logic [1:0]        state_dbg
);

  // One extra bit so a stack spanning the whole address range can report
  // DEPTH == 2**ADDR_W without wrapping to zero.
  localparam logic [ADDR_W:0]   DEPTH    = {1'b0, STACK_TOP} - {1'b0, STACK_BOTTOM} + 1'b1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e              state_q, state_d;
  cmd_op_e             op_in, op_q;
  logic                accept;
  logic                full, empty;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     hwm_q, hwm_d, hwm_base;
  logic [1:0]          err_q, err_set;
  logic [ADDR_W-1:0]   free_slot;

  assign op_in     = cmd_op_e'(cmd_op);
  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0);
  // Address arithmetic is modulo 2**ADDR_W; with a full-range stack the
  // truncated count still lands on the right slot.
  assign free_slot = STACK_TOP - count_q[ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: errors and CLEAR go straight to the response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_in)
            OP_PUSH:         state_d = full  ? ST_RESP : ST_MEM_WR;
            OP_POP, OP_PEEK: state_d = empty ? ST_RESP : ST_MEM_RD;
            default:         state_d = ST_RESP;
          endcase
        end
      end
      ST_MEM_WR, ST_MEM_RD: if (mem_ack) state_d = ST_RESP;
      ST_RESP:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory and response buses read zero when idle.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    mem_req   = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
    mem_we    = (state_q == ST_MEM_WR);
    mem_addr  = mem_req ? addr_q : '0;
    mem_wdata = mem_we ? wdata_q : '0;
    rsp_valid = (state_q == ST_RESP);
    rsp_data  = rsp_valid ? rsp_data_q : '0;
    rsp_err   = rsp_valid && rsp_err_q;
    sp        = free_slot;
    count     = count_q;
    hwm       = hwm_q;
    err_flags = err_q;
    state_dbg = state_q;
  end

  // Occupancy only moves on CLEAR acceptance or a completed push/pop access.
  always_comb begin
    count_d = count_q;
    if (accept && op_in == OP_CLEAR)                         count_d = '0;
    else if (state_q == ST_MEM_WR && mem_ack)                count_d = count_q + CNT_ONE;
    else if (state_q == ST_MEM_RD && mem_ack && op_q == OP_POP) count_d = count_q - CNT_ONE;
  end

  // Clearing the mark restarts it from the occupancy it will have next cycle,
  // so hwm never reads below count.
  always_comb begin
    hwm_base = err_clr ? '0 : hwm_q;
    hwm_d    = (count_d > hwm_base) ? count_d : hwm_base;
  end

  // Error events are raised on the accepting edge.
  always_comb begin
    err_set = '0;
    if (accept && op_in == OP_PUSH && full) err_set[ERR_OVERFLOW] = 1'b1;
    if (accept && (op_in == OP_POP || op_in == OP_PEEK) && empty)
      err_set[ERR_UNDERFLOW] = 1'b1;
  end

  // Counters and sticky flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      hwm_q   <= '0;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      hwm_q   <= hwm_d;
      err_q   <= (err_clr ? 2'b00 : err_q) | err_set;
    end
  end

  // Command capture and response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_PUSH;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      op_q       <= op_in;
      wdata_q    <= cmd_data;
      addr_q     <= (op_in == OP_PUSH) ? free_slot : free_slot + ADDR_ONE;
      rsp_data_q <= '0;
      rsp_err_q  <= |err_set;
    end else if (state_q == ST_MEM_WR && mem_ack) begin
      rsp_data_q <= wdata_q;
      rsp_err_q  <= 1'b0;
    end else if (state_q == ST_MEM_RD && mem_ack) begin
      rsp_data_q <= mem_rdata;
      rsp_err_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oni_stack_ctrl.sv
// Bench for oni_stack_ctrl on a 4-deep stack at 9000..9003: reset values,
// a vector table for the basic command flow, hand sequences for clear/error
// collision, a stretched memory access and reset mid-access, then random
// commands checked against a queue-based stack model.
module tb_oni_stack_ctrl;

  localparam logic [15:0] TOP   = 16'h9003;
  localparam logic [15:0] BOT   = 16'h9000;
  localparam int          DEPTH = 4;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [15:0] sp;
  logic [16:0] count, hwm;
  logic [1:0]  err_flags, state_dbg;
  logic        err_clr;

  oni_stack_ctrl #(
    .DATA_W(8), .ADDR_W(16), .STACK_TOP(TOP), .STACK_BOTTOM(BOT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sp(sp), .count(count), .hwm(hwm),
    .err_flags(err_flags), .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] mem [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: issues one command, plays the memory with dly wait cycles before
  // ack, and reports what the DUT did. lat counts cycles from accept to rsp.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input int dly,
                        input logic clr,
                        output logic [7:0] r_data, output logic r_err, output int lat,
                        output int req_cyc, output logic [15:0] a, output logic we,
                        output logic [7:0] wd, output logic stable, output logic ok,
                        output logic one_shot);
    r_data = '0; r_err = 0; lat = 0; req_cyc = 0; a = '0; we = 0; wd = '0;
    stable = 1; ok = 0; one_shot = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_data = data; err_clr = clr;
    @(negedge clk);
    cmd_valid = 0; cmd_data = '0; err_clr = 0;
    for (int k = 1; k <= 40 && !ok; k++) begin
      mem_ack = 0;
      if (rsp_valid) begin
        ok = 1; lat = k; r_data = rsp_data; r_err = rsp_err;
        if (mem_req) stable = 0;
      end else if (mem_req) begin
        if (req_cyc == 0) begin
          a = mem_addr; we = mem_we; wd = mem_wdata;
        end else if (mem_addr !== a || mem_we !== we || mem_wdata !== wd) begin
          stable = 0;
        end
        req_cyc++;
        if (req_cyc == dly + 1) begin
          mem_ack = 1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end
      if (!ok) @(negedge clk);
    end
    mem_ack = 0;
    @(negedge clk);
    one_shot = !rsp_valid && cmd_ready;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    int          dly;
    logic        clr;
    logic        exp_err;
    logic        chk_data;
    logic [7:0]  exp_data;
    logic        exp_mem;
    logic [15:0] exp_addr;
    logic [16:0] exp_count;
    logic [16:0] exp_hwm;
    logic [1:0]  exp_flags;
  } vec_t;

  vec_t vec [12];
  logic [7:0] stk [$];

  initial begin
    logic [7:0]  r_data, wd;
    logic        r_err, we, stable, ok, one_shot;
    logic [15:0] a;
    int          lat, req_cyc;

    reset = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    mem_ack = 0; mem_rdata = 0; err_clr = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Reset state.
    chk("rst_ready", cmd_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_hwm", hwm, 0);
    chk("rst_flags", err_flags, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_sp", sp, TOP);

    //            op    data   dly clr err cd  data   mem addr      cnt hwm flags
    vec[0]  = '{2'd0, 8'hA1, 0, 0, 0, 1, 8'hA1, 1, 16'h9003, 1, 1, 2'b00};
    vec[1]  = '{2'd0, 8'hB2, 0, 0, 0, 1, 8'hB2, 1, 16'h9002, 2, 2, 2'b00};
    vec[2]  = '{2'd2, 8'h00, 0, 0, 0, 1, 8'hB2, 1, 16'h9002, 2, 2, 2'b00};
    vec[3]  = '{2'd1, 8'h00, 1, 0, 0, 1, 8'hB2, 1, 16'h9002, 1, 2, 2'b00};
    vec[4]  = '{2'd1, 8'h00, 0, 0, 0, 1, 8'hA1, 1, 16'h9003, 0, 2, 2'b00};
    vec[5]  = '{2'd1, 8'h00, 0, 0, 1, 1, 8'h00, 0, 16'h0000, 0, 2, 2'b01};
    vec[6]  = '{2'd0, 8'h11, 0, 1, 0, 1, 8'h11, 1, 16'h9003, 1, 1, 2'b00};
    vec[7]  = '{2'd0, 8'h22, 0, 0, 0, 1, 8'h22, 1, 16'h9002, 2, 2, 2'b00};
    vec[8]  = '{2'd0, 8'h33, 2, 0, 0, 1, 8'h33, 1, 16'h9001, 3, 3, 2'b00};
    vec[9]  = '{2'd0, 8'h44, 0, 0, 0, 1, 8'h44, 1, 16'h9000, 4, 4, 2'b00};
    vec[10] = '{2'd0, 8'h55, 0, 0, 1, 0, 8'h00, 0, 16'h0000, 4, 4, 2'b10};
    vec[11] = '{2'd3, 8'h00, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 4, 2'b10};

    for (int i = 0; i < 12; i++) begin
      do_cmd(vec[i].op, vec[i].data, vec[i].dly, vec[i].clr,
             r_data, r_err, lat, req_cyc, a, we, wd, stable, ok, one_shot);
      chk($sformatf("v%0d_rsp_seen", i), ok, 1);
      chk($sformatf("v%0d_err", i), r_err, vec[i].exp_err);
      if (vec[i].chk_data) chk($sformatf("v%0d_data", i), r_data, vec[i].exp_data);
      chk($sformatf("v%0d_lat", i), lat, vec[i].exp_mem ? vec[i].dly + 2 : 1);
      chk($sformatf("v%0d_req_cycles", i), req_cyc, vec[i].exp_mem ? vec[i].dly + 1 : 0);
      if (vec[i].exp_mem) begin
        chk($sformatf("v%0d_addr", i), a, vec[i].exp_addr);
        chk($sformatf("v%0d_we", i), we, vec[i].op == 2'd0);
      end
      chk($sformatf("v%0d_count", i), count, vec[i].exp_count);
      chk($sformatf("v%0d_sp", i), sp, TOP - vec[i].exp_count[15:0]);
      chk($sformatf("v%0d_hwm", i), hwm, vec[i].exp_hwm);
      chk($sformatf("v%0d_flags", i), err_flags, vec[i].exp_flags);
      chk($sformatf("v%0d_one_shot", i), one_shot, 1);
    end

    // Idle clear, then a clear colliding with an underflow: the new error wins.
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("clr_flags", err_flags, 2'b00);
    chk("clr_hwm", hwm, 0);
    do_cmd(2'd1, 8'h00, 0, 1, r_data, r_err, lat, req_cyc, a, we, wd, stable, ok, one_shot);
    chk("uf_err", r_err, 1);
    chk("uf_data", r_data, 0);
    chk("uf_lat", lat, 1);
    chk("uf_flags", err_flags, 2'b01);

    // Memory holds off ack for three cycles.
    do_cmd(2'd0, 8'h5A, 3, 0, r_data, r_err, lat, req_cyc, a, we, wd, stable, ok, one_shot);
    chk("slow_req_cycles", req_cyc, 4);
    chk("slow_stable", stable, 1);
    chk("slow_addr", a, 16'h9003);
    chk("slow_wdata", wd, 8'h5A);
    chk("slow_lat", lat, 5);
    chk("slow_one_shot", one_shot, 1);
    chk("slow_count", count, 1);

    // Reset in the middle of a write, then a stray ack.
    @(negedge clk); cmd_valid = 1; cmd_op = 2'd0; cmd_data = 8'h77;
    @(negedge clk); cmd_valid = 0;
    chk("mid_req_before", mem_req, 1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_req", mem_req, 0);
    chk("mid_count", count, 0);
    chk("mid_hwm", hwm, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_ready", cmd_ready, 1);
    @(negedge clk); reset = 1;
    @(negedge clk); mem_ack = 1; mem_rdata = 8'hEE;
    @(negedge clk); mem_ack = 0;
    chk("stray_rsp", rsp_valid, 0);
    chk("stray_req", mem_req, 0);
    chk("stray_count", count, 0);
    @(negedge clk);
    chk("stray_ready", cmd_ready, 1);

    // Random commands against a queue model of the stack.
    begin
      logic [16:0] hwm_m;
      logic [1:0]  flags_m;
      hwm_m = 0; flags_m = 0;
      stk.delete();
      for (int it = 0; it < 150; it++) begin
        int          r, dly;
        logic [1:0]  op;
        logic [7:0]  d, e_data;
        logic        clr, e_err, e_mem;
        logic [15:0] e_addr;
        r   = $urandom_range(0, 9);
        op  = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        d   = 8'($urandom_range(0, 255));
        dly = $urandom_range(0, 2);
        clr = ($urandom_range(0, 7) == 0);
        e_err = 0; e_mem = 0; e_data = 0; e_addr = 0;
        if (clr) begin
          flags_m = 0;
          hwm_m   = (op == 2'd3) ? 17'd0 : 17'(stk.size());
        end
        case (op)
          2'd0: if (stk.size() < DEPTH) begin
                  e_mem = 1; e_addr = TOP - 16'(stk.size()); e_data = d;
                  stk.push_back(d);
                end else begin
                  e_err = 1; flags_m[1] = 1;
                end
          2'd1, 2'd2: if (stk.size() > 0) begin
                  e_mem = 1; e_addr = TOP - 16'(stk.size() - 1); e_data = stk[$];
                  if (op == 2'd1) void'(stk.pop_back());
                end else begin
                  e_err = 1; flags_m[0] = 1;
                end
          default: stk.delete();
        endcase
        if (17'(stk.size()) > hwm_m) hwm_m = 17'(stk.size());

        do_cmd(op, d, dly, clr, r_data, r_err, lat, req_cyc, a, we, wd, stable, ok, one_shot);
        chk($sformatf("r%0d_rsp_seen", it), ok, 1);
        chk($sformatf("r%0d_err", it), r_err, e_err);
        if (op != 2'd3 && !(op == 2'd0 && e_err)) chk($sformatf("r%0d_data", it), r_data, e_data);
        chk($sformatf("r%0d_lat", it), lat, e_mem ? dly + 2 : 1);
        chk($sformatf("r%0d_req_cycles", it), req_cyc, e_mem ? dly + 1 : 0);
        if (e_mem) begin
          chk($sformatf("r%0d_addr", it), a, e_addr);
          chk($sformatf("r%0d_stable", it), stable, 1);
        end
        chk($sformatf("r%0d_count", it), count, 17'(stk.size()));
        chk($sformatf("r%0d_sp", it), sp, TOP - 16'(stk.size()));
        chk($sformatf("r%0d_hwm", it), hwm, hwm_m);
        chk($sformatf("r%0d_flags", it), err_flags, flags_m);
        chk($sformatf("r%0d_one_shot", it), one_shot, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
